// File: rtl/mem_transfer_sequencer_if.sv
// Bundle between the CPU control unit, the transfer sequencer and the memory manager.
// slave = sequencer side, master = control unit / memory manager side.
interface mem_transfer_sequencer_if #(
   parameter int ADDR_W = 12
);
   logic              start;
   logic [1:0]        op;
   logic [3:0]        reg_x;
   logic [ADDR_W-1:0] index_i;
   logic [ADDR_W-1:0] pc_in;
   logic [127:0]      v_regs;
   logic [127:0]      read_buffer;
   logic [15:0]       opcode_in;

   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] pc;
   logic [5:0]        address_counter;
   logic              write_enable;
   logic [3:0]        write_count;
   logic [127:0]      write_buffer;
   logic              busy;
   logic              done;
   logic [127:0]      load_data;
   logic [15:0]       load_mask;
   logic [15:0]       opcode_out;
   logic [ADDR_W-1:0] index_out;
   logic              index_update;

   modport slave (
      input  start, op, reg_x, index_i, pc_in, v_regs, read_buffer, opcode_in,
      output address, pc, address_counter, write_enable, write_count, write_buffer,
             busy, done, load_data, load_mask, opcode_out, index_out, index_update
   );

   modport master (
      output start, op, reg_x, index_i, pc_in, v_regs, read_buffer, opcode_in,
      input  address, pc, address_counter, write_enable, write_count, write_buffer,
             busy, done, load_data, load_mask, opcode_out, index_out, index_update
   );
endinterface

// File: rtl/mem_transfer_sequencer.sv
// Sequences one CHIP-8 memory transaction (fetch / FX55 store / FX65 load) through the memory manager.
// Optional macro CHIP8_INDEX_INCREMENT_EN: I advances by X+1 after store/load (COSMAC semantics).
module mem_transfer_sequencer #(
   parameter int ADDR_W     = 12,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   mem_transfer_sequencer_if.slave bus,
   output logic [1:0]              state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_FETCH = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_RSVD  = 2'b11;
   localparam logic [5:0] PD       = 6'(PIPE_DEPTH);

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [3:0]        reg_x_q, reg_x_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [127:0]      v_q, v_d;
   logic [15:0]       opcode_q, opcode_d;
   logic [127:0]      load_data_q, load_data_d;
   logic [15:0]       load_mask_q, load_mask_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] index_out_q, index_out_d;
   logic              index_upd_q, index_upd_d;

   logic [5:0]        term_w;
   logic [15:0]       mask_w;

   // Fetch moves two opcode bytes; store/load move X+1 bytes. Pipeline latency extends the count.
   always_comb begin
      term_w = (op_q == OP_FETCH) ? (PD + 6'd1) : ({2'b00, reg_x_q} + PD);
   end

   always_comb begin
      mask_w = '0;
      for (int k = 0; k < 16; k++) begin
         mask_w[k] = (k <= int'(reg_x_q));
      end
   end

   // Handshake: start is a one-cycle request taken only in IDLE (no ready/queueing; it is dropped
   // when busy or op is reserved); done is a one-cycle completion pulse with results valid alongside.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      reg_x_d     = reg_x_q;
      addr_d      = addr_q;
      pc_d        = pc_q;
      v_d         = v_q;
      opcode_d    = opcode_q;
      load_data_d = load_data_q;
      load_mask_d = load_mask_q;
      done_d      = 1'b0;
      index_out_d = index_out_q;
      index_upd_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.op != OP_RSVD)) begin
               op_d    = bus.op;
               reg_x_d = bus.reg_x;
               addr_d  = bus.index_i;
               pc_d    = bus.pc_in;
               v_d     = bus.v_regs;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == term_w) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_DONE: begin
            if (op_q == OP_FETCH) begin
               opcode_d = bus.opcode_in;
            end else if (op_q != OP_STORE) begin
               load_data_d = bus.read_buffer;
               load_mask_d = mask_w;
            end
`ifdef CHIP8_INDEX_INCREMENT_EN
            if (op_q != OP_FETCH) begin
               index_out_d = addr_q + ADDR_W'(reg_x_q) + ADDR_W'(1);
               index_upd_d = 1'b1;
            end
`else
            index_out_d = '0;
`endif
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         reg_x_q     <= '0;
         addr_q      <= '0;
         pc_q        <= '0;
         v_q         <= '0;
         opcode_q    <= '0;
         load_data_q <= '0;
         load_mask_q <= '0;
         done_q      <= 1'b0;
         index_out_q <= '0;
         index_upd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         reg_x_q     <= reg_x_d;
         addr_q      <= addr_d;
         pc_q        <= pc_d;
         v_q         <= v_d;
         opcode_q    <= opcode_d;
         load_data_q <= load_data_d;
         load_mask_q <= load_mask_d;
         done_q      <= done_d;
         index_out_q <= index_out_d;
         index_upd_q <= index_upd_d;
      end
   end

   logic active_w;
   logic store_act_w;
   assign active_w    = (state_q != S_IDLE);
   assign store_act_w = active_w && (op_q == OP_STORE);

   assign bus.address         = addr_q;
   assign bus.pc              = pc_q;
   assign bus.address_counter = cnt_q;
   assign bus.write_enable    = (state_q == S_RUN) && (op_q == OP_STORE);
   assign bus.write_count     = store_act_w ? reg_x_q : 4'd0;
   assign bus.write_buffer    = store_act_w ? v_q : 128'd0;
   assign bus.busy            = active_w;
   assign bus.done            = done_q;
   assign bus.load_data       = load_data_q;
   assign bus.load_mask       = load_mask_q;
   assign bus.opcode_out      = opcode_q;
   assign bus.index_out       = index_out_q;
   assign bus.index_update    = index_upd_q;
   assign state_o             = state_q;

endmodule

// File: tb/tb_mem_transfer_sequencer.sv
// Directed bench for mem_transfer_sequencer: fetch, store, load, reset abort, ignored starts, index update.
module tb_mem_transfer_sequencer;
   logic clk = 1'b0;
   logic reset;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   mem_transfer_sequencer_if bus ();

   mem_transfer_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (dbg_state)
   );

   int checks = 0;
   int failures = 0;

   logic [5:0]   trace_q[$];
   logic [5:0]   exp_q[$];
   int           cyc;
   int           we_cnt;
   logic [3:0]   first_wc;
   logic [11:0]  first_addr;
   logic [127:0] first_wb;

   localparam logic [127:0] V_STORE = {96'h0, 32'h44332211};
   localparam logic [127:0] RB_A    = {4{32'hDEADBEEF}};
   localparam logic [127:0] RB_B    = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and follows it until done (bounded); records counter trace and write strobes.
   task automatic run_txn(input logic [1:0] op_v, input logic [3:0] x, input logic [11:0] idx,
                          input logic [11:0] pcv, input bit poke);
      bus.start   = 1'b1;
      bus.op      = op_v;
      bus.reg_x   = x;
      bus.index_i = idx;
      bus.pc_in   = pcv;
      step();
      bus.start = 1'b0;
      trace_q.delete();
      we_cnt     = 0;
      cyc        = -1;
      first_wc   = bus.write_count;
      first_addr = bus.address;
      first_wb   = bus.write_buffer;
      for (int n = 0; n <= 40; n++) begin
         if (bus.done) begin
            cyc = n;
            break;
         end
         trace_q.push_back(bus.address_counter);
         if (bus.write_enable) we_cnt++;
         if (poke && n == 2) begin
            bus.start = 1'b1;
            bus.op    = 2'b10;
         end
         step();
         bus.start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({bus.busy, bus.done, bus.write_enable, bus.index_update} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {bus.busy, bus.done, bus.write_enable, bus.index_update});
      end
      checks++;
      if (bus.address_counter !== 6'd0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_state: got cnt=%0d st=%0d expected 0 0", bus.address_counter, dbg_state);
      end
      checks++;
      if ({bus.opcode_out, bus.load_mask, bus.index_out, bus.address, bus.pc} !== 68'd0) begin
         failures++;
         $display("FAIL reset_regs: got op=%h mask=%h idx=%h addr=%h pc=%h expected all 0",
                  bus.opcode_out, bus.load_mask, bus.index_out, bus.address, bus.pc);
      end
      checks++;
      if (bus.load_data !== 128'd0 || bus.write_buffer !== 128'd0 || bus.write_count !== 4'd0) begin
         failures++;
         $display("FAIL reset_data: got ld=%h wb=%h wc=%h expected 0", bus.load_data, bus.write_buffer,
                  bus.write_count);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      int mism;
      bus.opcode_in = 16'h6A05;
      run_txn(2'b00, 4'd9, 12'h123, 12'h200, 1'b0);
      checks++;
      if (cyc !== 5) begin
         failures++;
         $display("FAIL fetch_latency: got %0d expected 5", cyc);
      end
      exp_q.delete();
      for (int i = 0; i <= 3; i++) exp_q.push_back(6'(i));
      exp_q.push_back(6'd3);
      mism = (trace_q.size() != exp_q.size()) ? 1 : 0;
      if (mism == 0) foreach (exp_q[i]) if (trace_q[i] !== exp_q[i]) mism++;
      checks++;
      if (mism != 0) begin
         failures++;
         $display("FAIL fetch_counter: got %p expected %p", trace_q, exp_q);
      end
      checks++;
      if (bus.opcode_out !== 16'h6A05 || bus.pc !== 12'h200) begin
         failures++;
         $display("FAIL fetch_result: got op=%h pc=%h expected 6a05 200", bus.opcode_out, bus.pc);
      end
      checks++;
      if (we_cnt !== 0 || bus.busy !== 1'b0 || bus.load_mask !== 16'h0) begin
         failures++;
         $display("FAIL fetch_side: got we=%0d busy=%b mask=%h expected 0 0 0", we_cnt, bus.busy,
                  bus.load_mask);
      end
      step();
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL fetch_done_pulse: got %b expected 0", bus.done);
      end
   endtask

   task automatic test_store();
      logic [11:0] exp_idx;
      logic        exp_upd;
`ifdef CHIP8_INDEX_INCREMENT_EN
      exp_idx = 12'h304;
      exp_upd = 1'b1;
`else
      exp_idx = 12'h000;
      exp_upd = 1'b0;
`endif
      bus.v_regs = V_STORE;
      run_txn(2'b01, 4'd3, 12'h300, 12'h456, 1'b0);
      checks++;
      if (cyc !== 7 || we_cnt !== 6) begin
         failures++;
         $display("FAIL store_timing: got cyc=%0d we=%0d expected 7 6", cyc, we_cnt);
      end
      checks++;
      if (first_wc !== 4'd3 || first_addr !== 12'h300 || first_wb !== V_STORE) begin
         failures++;
         $display("FAIL store_bus: got wc=%0d addr=%h wb=%h expected 3 300 %h", first_wc, first_addr,
                  first_wb, V_STORE);
      end
      checks++;
      if (bus.load_mask !== 16'h0 || bus.opcode_out !== 16'h6A05) begin
         failures++;
         $display("FAIL store_hold: got mask=%h op=%h expected 0000 6a05", bus.load_mask, bus.opcode_out);
      end
      checks++;
      if (bus.index_out !== exp_idx || bus.index_update !== exp_upd) begin
         failures++;
         $display("FAIL store_index: got %h/%b expected %h/%b", bus.index_out, bus.index_update,
                  exp_idx, exp_upd);
      end
      checks++;
      if (bus.write_count !== 4'd0 || bus.write_buffer !== 128'd0 || bus.write_enable !== 1'b0) begin
         failures++;
         $display("FAIL store_idle_bus: got wc=%0d wb=%h we=%b expected 0", bus.write_count,
                  bus.write_buffer, bus.write_enable);
      end
   endtask

   task automatic test_load_max();
      logic [11:0] exp_idx;
`ifdef CHIP8_INDEX_INCREMENT_EN
      exp_idx = 12'h060;
`else
      exp_idx = 12'h000;
`endif
      bus.read_buffer = RB_A;
      run_txn(2'b10, 4'd15, 12'h050, 12'h000, 1'b0);
      checks++;
      if (cyc !== 19 || we_cnt !== 0) begin
         failures++;
         $display("FAIL load_timing: got cyc=%0d we=%0d expected 19 0", cyc, we_cnt);
      end
      checks++;
      if (trace_q.size() != 19 || trace_q[17] !== 6'd17 || trace_q[18] !== 6'd17) begin
         failures++;
         $display("FAIL load_counter: got %p expected 0..17,17", trace_q);
      end
      checks++;
      if (bus.load_data !== RB_A || bus.load_mask !== 16'hFFFF) begin
         failures++;
         $display("FAIL load_result: got ld=%h mask=%h expected %h ffff", bus.load_data, bus.load_mask,
                  RB_A);
      end
      checks++;
      if (bus.index_out !== exp_idx) begin
         failures++;
         $display("FAIL load_index: got %h expected %h", bus.index_out, exp_idx);
      end
   endtask

   task automatic test_index_wrap();
      bus.read_buffer = RB_B;
      run_txn(2'b10, 4'd2, 12'hFFE, 12'h000, 1'b0);
      checks++;
      if (cyc !== 6 || bus.load_mask !== 16'h0007 || bus.load_data !== RB_B) begin
         failures++;
         $display("FAIL wrap_load: got cyc=%0d mask=%h expected 6 0007", cyc, bus.load_mask);
      end
`ifdef CHIP8_INDEX_INCREMENT_EN
      checks++;
      if (bus.index_out !== 12'h001 || bus.index_update !== 1'b1 || bus.done !== 1'b1) begin
         failures++;
         $display("FAIL wrap_index: got %h upd=%b done=%b expected 001 1 1", bus.index_out,
                  bus.index_update, bus.done);
      end
`else
      checks++;
      if (bus.index_out !== 12'h000 || bus.index_update !== 1'b0) begin
         failures++;
         $display("FAIL wrap_index: got %h upd=%b expected 000 0", bus.index_out, bus.index_update);
      end
`endif
      step();
      checks++;
      if (bus.index_update !== 1'b0) begin
         failures++;
         $display("FAIL wrap_index_pulse: got %b expected 0", bus.index_update);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      bus.start   = 1'b1;
      bus.op      = 2'b01;
      bus.reg_x   = 4'd3;
      bus.index_i = 12'h300;
      step();
      bus.start = 1'b0;
      step();
      step();
      checks++;
      if (bus.address_counter !== 6'd2 || bus.write_enable !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre: got cnt=%0d we=%b expected 2 1", bus.address_counter, bus.write_enable);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({bus.busy, bus.done, bus.write_enable, bus.address_counter, bus.write_count, dbg_state} !== 14'd0
          || bus.write_buffer !== 128'd0 || bus.load_data !== 128'd0 || bus.load_mask !== 16'd0
          || bus.address !== 12'd0 || bus.opcode_out !== 16'd0) begin
         failures++;
         $display("FAIL abort_outputs: got busy=%b done=%b we=%b cnt=%0d wc=%0d st=%0d expected all 0",
                  bus.busy, bus.done, bus.write_enable, bus.address_counter, bus.write_count, dbg_state);
      end
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.done || bus.busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
      end
      bus.opcode_in = 16'h1234;
      run_txn(2'b00, 4'd0, 12'h000, 12'h2A0, 1'b0);
      checks++;
      if (cyc !== 5 || bus.opcode_out !== 16'h1234 || bus.pc !== 12'h2A0) begin
         failures++;
         $display("FAIL abort_refetch: got cyc=%0d op=%h pc=%h expected 5 1234 2a0", cyc, bus.opcode_out,
                  bus.pc);
      end
   endtask

   task automatic test_ignore_and_back_to_back();
      int seen;
      bus.opcode_in = 16'hA123;
      run_txn(2'b00, 4'd0, 12'h000, 12'h300, 1'b1);
      checks++;
      if (cyc !== 5 || bus.opcode_out !== 16'hA123) begin
         failures++;
         $display("FAIL busy_start: got cyc=%0d op=%h expected 5 a123", cyc, bus.opcode_out);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (bus.busy || bus.done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL busy_start_queued: got %0d active cycles expected 0", seen);
      end
      bus.start = 1'b1;
      bus.op    = 2'b11;
      step();
      bus.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.busy || bus.done) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reserved_op: got %0d active cycles expected 0", seen);
      end
      bus.opcode_in = 16'h00E0;
      run_txn(2'b00, 4'd0, 12'h000, 12'h202, 1'b0);
      bus.read_buffer = RB_B;
      run_txn(2'b10, 4'd0, 12'h100, 12'h000, 1'b0);
      checks++;
      if (cyc !== 4 || bus.load_mask !== 16'h0001 || bus.opcode_out !== 16'h00E0) begin
         failures++;
         $display("FAIL back_to_back: got cyc=%0d mask=%h op=%h expected 4 0001 00e0", cyc, bus.load_mask,
                  bus.opcode_out);
      end
   endtask

   initial begin
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.op          = 2'b00;
      bus.reg_x       = 4'd0;
      bus.index_i     = 12'h000;
      bus.pc_in       = 12'h000;
      bus.v_regs      = 128'd0;
      bus.read_buffer = 128'd0;
      bus.opcode_in   = 16'h0000;
      test_reset();
      test_fetch();
      test_store();
      test_load_max();
      test_index_wrap();
      test_reset_mid();
      test_ignore_and_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
